// File: rtl/fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl
//   Read-domain controller of an asynchronous FIFO. Owns the binary/Gray read
//   pointer, drives the dual-port RAM read port, publishes the Gray read
//   pointer to the write-domain synchronizer and derives a registered empty
//   flag from the synchronized Gray write pointer. A read is only issued to
//   the RAM while the FIFO is not empty; a request while empty is recorded in
//   a sticky underflow flag instead.
//
// Optional feature (compile-time macro): FIFO_RD_LEVEL_EN
//   Defined   : rd_count is the registered occupancy seen from the read side
//               and almost_empty compares it against AEMPTY_THRESH.
//   Undefined : no Gray-to-binary decode; rd_count is tied to 0 and
//               almost_empty follows empty.
//
// Parameters
//   ADDR_WIDTH     RAM address bits; pointers carry one extra wrap bit
//   AEMPTY_THRESH  almost_empty asserts when occupancy <= this value
//
// Ports
//   clk             in   read-domain clock
//   rst_n           in   asynchronous active-low reset
//   rd_en           in   consumer read request
//   wptr_gray_sync  in   Gray write pointer, already synchronized into clk
//   underflow_clr   in   clears the sticky underflow flag
//   rptr_gray       out  registered Gray read pointer
//   rd_addr         out  RAM read address (low bits of binary read pointer)
//   mem_rd_en       out  RAM read strobe, combinational rd_en & ~empty
//   rd_valid        out  RAM output valid, one cycle after an accepted read
//   empty           out  registered empty flag
//   almost_empty    out  occupancy at or below AEMPTY_THRESH
//   underflow       out  sticky: rd_en seen while empty
//   rd_count        out  occupancy seen from the read side
// -----------------------------------------------------------------------------
module fifo_rd_ctrl #(
   parameter int ADDR_WIDTH    = 6,
   parameter int AEMPTY_THRESH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH:0]   wptr_gray_sync,
   input  logic                  underflow_clr,
   output logic [ADDR_WIDTH:0]   rptr_gray,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  mem_rd_en,
   output logic                  rd_valid,
   output logic                  empty,
   output logic                  almost_empty,
   output logic                  underflow,
   output logic [ADDR_WIDTH:0]   rd_count
);

   localparam int PW = ADDR_WIDTH + 1;
   typedef logic [PW-1:0] ptr_t;

   // Reject thresholds that no occupancy value could ever be compared against.
   if (AEMPTY_THRESH < 0 || AEMPTY_THRESH >= (1 << PW)) begin : g_bad_thresh
      $error("fifo_rd_ctrl: AEMPTY_THRESH out of range");
   end

   function automatic ptr_t bin2gray(input ptr_t b);
      return b ^ (b >> 1);
   endfunction

   ptr_t rptr_bin;
   ptr_t rptr_bin_next;
   ptr_t rptr_gray_next;
   logic accept;
   logic empty_next;

   // A read reaches the RAM only when the registered flag says data is there.
   assign accept    = rd_en & ~empty;
   assign mem_rd_en = accept;
   assign rd_addr   = rptr_bin[ADDR_WIDTH-1:0];

   // Empty is evaluated against the post-accept pointer so the edge that
   // consumes the last entry also raises empty; no second read can slip in.
   // Comparing all PW bits keeps the "full" case (same low bits, different
   // wrap bit) from ever looking empty.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned and infers a latch.
      rptr_bin_next  = rptr_bin + ptr_t'(accept);
      rptr_gray_next = bin2gray(rptr_bin_next);
      empty_next     = (rptr_gray_next == wptr_gray_sync);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rptr_bin  <= '0;
         rptr_gray <= '0;
         empty     <= 1'b1;
         rd_valid  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values of the others.
         rptr_bin  <= rptr_bin_next;
         rptr_gray <= rptr_gray_next;
         empty     <= empty_next;
         rd_valid  <= accept;
         // Set has priority over clear so a request arriving together with
         // the clear is never lost.
         if (rd_en && empty) begin
            underflow <= 1'b1;
         end else if (underflow_clr) begin
            underflow <= 1'b0;
         end
      end
   end

`ifdef FIFO_RD_LEVEL_EN

   localparam ptr_t AE_TH = ptr_t'(AEMPTY_THRESH);

   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   ptr_t wbin;
   ptr_t rd_count_next;
   logic almost_empty_next;

   // Modular subtraction handles pointer wrap; the synchronized write pointer
   // can only lag, so the count is pessimistic just like empty.
   always_comb begin
      wbin              = gray2bin(wptr_gray_sync);
      rd_count_next     = wbin - rptr_bin_next;
      almost_empty_next = (rd_count_next <= AE_TH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_count     <= '0;
         almost_empty <= 1'b1;
      end else begin
         rd_count     <= rd_count_next;
         almost_empty <= almost_empty_next;
      end
   end

`else

   assign rd_count     = '0;
   assign almost_empty = empty;

`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_ctrl
//   Self-checking bench for fifo_rd_ctrl. Two instances: u_dut (ADDR_WIDTH=6)
//   for draining, underflow, reset and level behaviour, and u_wrap
//   (ADDR_WIDTH=2) for pointer wrap-around. Accepted reads on u_dut are
//   scoreboarded: stimulus pushes the expected RAM address and data, and a
//   monitor pops them when mem_rd_en / rd_valid appear. A small RAM model
//   with registered output stands in for the dual-port RAM.
// -----------------------------------------------------------------------------
module tb_fifo_rd_ctrl;

`ifdef FIFO_RD_LEVEL_EN
   localparam bit LVL = 1'b1;
`else
   localparam bit LVL = 1'b0;
`endif

   logic clk;
   logic rst_n;

   // u_dut signals
   logic       rd_en;
   logic [6:0] wptr;
   logic       uclr;
   logic [6:0] rptr_gray;
   logic [5:0] rd_addr;
   logic       mem_rd_en;
   logic       rd_valid;
   logic       empty;
   logic       almost_empty;
   logic       underflow;
   logic [6:0] rd_count;

   // u_wrap signals
   logic       w_rd_en;
   logic [2:0] w_wptr;
   logic       w_uclr;
   logic [2:0] w_rptr_gray;
   logic [1:0] w_rd_addr;
   logic       w_mem_rd_en;
   logic       w_rd_valid;
   logic       w_empty;
   logic       w_almost_empty;
   logic       w_underflow;
   logic [2:0] w_rd_count;

   int checks   = 0;
   int failures = 0;

   logic [5:0] exp_addr_q[$];
   logic [7:0] exp_data_q[$];
   logic [7:0] ram_q;

   fifo_rd_ctrl #(.ADDR_WIDTH(6), .AEMPTY_THRESH(4)) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rd_en         (rd_en),
      .wptr_gray_sync(wptr),
      .underflow_clr (uclr),
      .rptr_gray     (rptr_gray),
      .rd_addr       (rd_addr),
      .mem_rd_en     (mem_rd_en),
      .rd_valid      (rd_valid),
      .empty         (empty),
      .almost_empty  (almost_empty),
      .underflow     (underflow),
      .rd_count      (rd_count)
   );

   fifo_rd_ctrl #(.ADDR_WIDTH(2), .AEMPTY_THRESH(1)) u_wrap (
      .clk           (clk),
      .rst_n         (rst_n),
      .rd_en         (w_rd_en),
      .wptr_gray_sync(w_wptr),
      .underflow_clr (w_uclr),
      .rptr_gray     (w_rptr_gray),
      .rd_addr       (w_rd_addr),
      .mem_rd_en     (w_mem_rd_en),
      .rd_valid      (w_rd_valid),
      .empty         (w_empty),
      .almost_empty  (w_almost_empty),
      .underflow     (w_underflow),
      .rd_count      (w_rd_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM stand-in: location a holds 0x40 + a, output registered.
   always @(posedge clk) begin
      if (mem_rd_en) ram_q <= 8'h40 + {2'b00, rd_addr};
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_read(input logic [5:0] addr);
      exp_addr_q.push_back(addr);
      exp_data_q.push_back(8'h40 + {2'b00, addr});
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_rd_en) begin
            if (exp_addr_q.size() == 0) check("unexpected_mem_rd_en", 32'(rd_addr), 32'hFFFF_FFFF);
            else check("sb_rd_addr", 32'(rd_addr), 32'(exp_addr_q.pop_front()));
         end
         if (rd_valid) begin
            if (exp_data_q.size() == 0) check("unexpected_rd_valid", 32'(ram_q), 32'hFFFF_FFFF);
            else check("sb_rd_data", 32'(ram_q), 32'(exp_data_q.pop_front()));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [2:0] gray_tab[8];
   logic [2:0] prev_gray;

   initial begin
      gray_tab = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
      rst_n   = 1'b0;
      rd_en   = 1'b0;
      wptr    = '0;
      uclr    = 1'b0;
      w_rd_en = 1'b0;
      w_wptr  = '0;
      w_uclr  = 1'b0;

      // ---- reset state ----
      repeat (3) step();
      rst_n = 1'b1;
      #1;
      check("rst_empty",        32'(empty),        32'd1);
      check("rst_rptr_gray",    32'(rptr_gray),    32'd0);
      check("rst_rd_valid",     32'(rd_valid),     32'd0);
      check("rst_underflow",    32'(underflow),    32'd0);
      check("rst_almost_empty", 32'(almost_empty), 32'd1);
      check("rst_rd_count",     32'(rd_count),     32'd0);

      // ---- drain 3: write pointer advances to gray 3 ----
      wptr = 7'b0000010;
      step();
      check("d3_empty_drop",   32'(empty),        32'd0);
      check("d3_rd_count",     32'(rd_count),     LVL ? 32'd3 : 32'd0);
      check("d3_almost_empty", 32'(almost_empty), LVL ? 32'd1 : 32'd0);
      rd_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         push_read(6'(k));
         step();
      end
      rd_en = 1'b0;
      check("d3_empty_after",  32'(empty),     32'd1);
      check("d3_rptr_gray",    32'(rptr_gray), 32'h02);
      check("d3_last_valid",   32'(rd_valid),  32'd1);

      // ---- underflow ----
      rd_en = 1'b1;
      #1;
      check("uf_mem_rd_en",    32'(mem_rd_en), 32'd0);
      check("uf_rd_addr",      32'(rd_addr),   32'd3);
      step();
      check("uf_set",          32'(underflow), 32'd1);
      check("uf_ptr_hold",     32'(rptr_gray), 32'h02);
      check("uf_no_valid",     32'(rd_valid),  32'd0);
      uclr = 1'b1;
      step();
      check("uf_set_wins",     32'(underflow), 32'd1);
      rd_en = 1'b0;
      step();
      check("uf_cleared",      32'(underflow), 32'd0);
      uclr = 1'b0;

      // ---- reset in the middle of a burst ----
      wptr = 7'b0001100;              // gray of 8
      step();
      check("mb_empty_drop",   32'(empty), 32'd0);
      rd_en = 1'b1;
      push_read(6'd3);
      step();
      push_read(6'd4);
      #2;
      rst_n = 1'b0;
      rd_en = 1'b0;
      wptr  = '0;
      exp_addr_q.delete();
      exp_data_q.delete();
      #1;
      check("mb_rst_empty",     32'(empty),        32'd1);
      check("mb_rst_rptr_gray", 32'(rptr_gray),    32'd0);
      check("mb_rst_rd_addr",   32'(rd_addr),      32'd0);
      check("mb_rst_rd_valid",  32'(rd_valid),     32'd0);
      check("mb_rst_underflow", 32'(underflow),    32'd0);
      check("mb_rst_mem_rd_en", 32'(mem_rd_en),    32'd0);
      check("mb_rst_aempty",    32'(almost_empty), 32'd1);
      repeat (2) step();
      rst_n = 1'b1;

      // ---- level: write pointer at binary 5 ----
      wptr = 7'b0000111;
      step();
      check("lv_empty",        32'(empty),        32'd0);
      check("lv_count5",       32'(rd_count),     LVL ? 32'd5 : 32'd0);
      check("lv_aempty5",      32'(almost_empty), 32'd0);
      rd_en = 1'b1;
      push_read(6'd0);
      step();
      rd_en = 1'b0;
      check("lv_count4",       32'(rd_count),     LVL ? 32'd4 : 32'd0);
      check("lv_aempty4",      32'(almost_empty), LVL ? 32'd1 : 32'd0);

      // ---- read and write-pointer change on the same edge ----
      rd_en = 1'b1;
      wptr  = 7'b0000101;             // gray of 6
      push_read(6'd1);
      step();
      rd_en = 1'b0;
      check("sim_empty",       32'(empty),        32'd0);
      check("sim_rd_count",    32'(rd_count),     LVL ? 32'd4 : 32'd0);
      check("sim_aempty",      32'(almost_empty), LVL ? 32'd1 : 32'd0);
      check("sim_rptr_gray",   32'(rptr_gray),    32'h03);

      // ---- drain the remaining 4 ----
      rd_en = 1'b1;
      for (int k = 2; k < 6; k++) begin
         push_read(6'(k));
         step();
      end
      rd_en = 1'b0;
      check("dr_empty",        32'(empty),        32'd1);
      check("dr_rd_count",     32'(rd_count),     32'd0);
      check("dr_aempty",       32'(almost_empty), 32'd1);
      check("dr_rptr_gray",    32'(rptr_gray),    32'h05);
      step();

      // ---- wrap on the 2-bit instance: 9 writes/reads in lockstep ----
      for (int i = 0; i < 9; i++) begin
         w_wptr = gray_tab[(i + 1) % 8];
         step();
         check("wr_empty_drop", 32'(w_empty), 32'd0);
         w_rd_en = 1'b1;
         #1;
         check("wr_rd_addr",    32'(w_rd_addr),   32'(i % 4));
         check("wr_mem_rd_en",  32'(w_mem_rd_en), 32'd1);
         prev_gray = w_rptr_gray;
         step();
         w_rd_en = 1'b0;
         check("wr_rptr_gray",  32'(w_rptr_gray), 32'(gray_tab[(i + 1) % 8]));
         check("wr_gray_1bit",  32'($countones(prev_gray ^ w_rptr_gray)), 32'd1);
         check("wr_empty",      32'(w_empty),     32'd1);
         check("wr_rd_valid",   32'(w_rd_valid),  32'd1);
      end
      // Read pointer is binary 1; write pointer binary 5 is a full FIFO.
      w_wptr = 3'b111;
      step();
      check("wr_full_not_empty", 32'(w_empty),     32'd0);
      check("wr_no_underflow",   32'(w_underflow), 32'd0);

      repeat (2) step();
      check("sb_addr_drained", 32'(exp_addr_q.size()), 32'd0);
      check("sb_data_drained", 32'(exp_data_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
